// File: rtl/reg_dump_tx.sv
// reg_dump_tx: walks the register bank and streams each 16-bit value as two 8N1 UART frames.
// Define REG_DUMP_CHECKSUM_EN to append an XOR-of-all-bytes frame after the last register.
//
// state | meaning
// IDLE  | tx high, waiting for start
// LOAD  | one cycle; capture reg_data for the current reg_sel
// START | start bit (tx low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (tx high); selects next byte, next register, checksum or finish
module reg_dump_tx #(
  parameter int NUM_REGS     = 8,
  parameter int SEL_W        = 3,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      reg_data,
  output logic [SEL_W-1:0] reg_sel,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] baud, baud_d;
  logic [2:0]       bit_idx, bit_d;
  logic             byte_idx, byte_d;
  logic [15:0]      buffer, buffer_d;
  logic [SEL_W-1:0] sel_d;
  logic             tx_d, busy_d, done_d;
  logic [7:0]       next_byte;
  logic             baud_wrap;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0] acc, acc_d;
  logic       cks, cks_d;
`endif

  assign baud_wrap = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= 1'b0;
      buffer   <= '0;
      reg_sel  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      acc      <= '0;
      cks      <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      baud     <= baud_d;
      bit_idx  <= bit_d;
      byte_idx <= byte_d;
      buffer   <= buffer_d;
      reg_sel  <= sel_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      acc      <= acc_d;
      cks      <= cks_d;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    baud_d    = baud;
    bit_d     = bit_idx;
    byte_d    = byte_idx;
    buffer_d  = buffer;
    sel_d     = reg_sel;
    busy_d    = busy;
    done_d    = 1'b0;
    next_byte = 8'h00;
    tx_d      = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
    acc_d     = acc;
    cks_d     = cks;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
          sel_d   = '0;
`ifdef REG_DUMP_CHECKSUM_EN
          acc_d   = '0;
          cks_d   = 1'b0;
`endif
        end
      end

      LOAD: begin
        buffer_d = reg_data;
        byte_d   = 1'b0;
        baud_d   = '0;
        bit_d    = '0;
        state_d  = START;
`ifdef REG_DUMP_CHECKSUM_EN
        acc_d    = acc ^ reg_data[7:0] ^ reg_data[15:8];
`endif
      end

      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud + 1'b1;
        end
      end

      DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_idx + 1'b1;
          end
        end else begin
          baud_d = baud + 1'b1;
        end
      end

      STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
`ifdef REG_DUMP_CHECKSUM_EN
          if (cks) begin
            state_d = IDLE;
            sel_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cks_d   = 1'b0;
          end else if (byte_idx == 1'b0) begin
            byte_d  = 1'b1;
            state_d = START;
          end else if (reg_sel < SEL_LAST) begin
            sel_d   = reg_sel + 1'b1;
            state_d = LOAD;
          end else begin
            // checksum frame follows directly, no LOAD cycle
            cks_d   = 1'b1;
            state_d = START;
          end
`else
          if (byte_idx == 1'b0) begin
            byte_d  = 1'b1;
            state_d = START;
          end else if (reg_sel < SEL_LAST) begin
            sel_d   = reg_sel + 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
            sel_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
`endif
        end else begin
          baud_d = baud + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // tx is registered: derive it from where the FSM will be next cycle
    next_byte = byte_d ? buffer_d[15:8] : buffer_d[7:0];
`ifdef REG_DUMP_CHECKSUM_EN
    if (cks_d) next_byte = acc_d;
`endif
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = next_byte[bit_d];
    else                      tx_d = 1'b1;
  end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: bank model on reg_sel, UART byte capture, timing and reset checks.
// Build with REG_DUMP_CHECKSUM_EN defined to also check the trailing checksum frame.
module tb_reg_dump_tx;

  localparam int CPB   = 16;
  localparam int NREGS = 8;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int DUMP_LEN = NREGS * (1 + 20 * CPB) + 10 * CPB;
`else
  localparam int DUMP_LEN = NREGS * (1 + 20 * CPB);
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] reg_data;
  logic [2:0]  reg_sel;
  logic        tx, busy, done;

  logic [15:0] bank [NREGS];
  logic [7:0]  exp_b [2*NREGS];

  int checks = 0;
  int passes = 0;
  int frame_err = 0;

  int busy_cnt = 0;
  int done_cnt = 0;
  int sel_steps = 0;
  int sel_bad = 0;
  logic [2:0] prev_sel = '0;

  assign reg_data = bank[reg_sel];

  always #5 clk = ~clk;

  reg_dump_tx #(.NUM_REGS(NREGS), .SEL_W(3), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .start(start), .reg_data(reg_data),
    .reg_sel(reg_sel), .tx(tx), .busy(busy), .done(done)
  );

  // running totals; the main sequence takes differences around each dump
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (reg_sel !== prev_sel) begin
      if (32'(reg_sel) == 32'(prev_sel) + 1) sel_steps <= sel_steps + 1;
      else if (reg_sel !== 3'd0) sel_bad <= sel_bad + 1;
      prev_sel <= reg_sel;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic rx_byte(input string tag, output logic [7:0] b);
    int n = 0;
    b = 8'h00;
    while (tx !== 1'b0 && n < 4 * CPB) begin
      tick();
      n++;
    end
    chk({tag, "_start_seen"}, {31'd0, tx}, 32'd0);
    repeat (CPB / 2) tick();
    if (tx !== 1'b0) frame_err++;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      b[i] = tx;
    end
    repeat (CPB) tick();
    if (tx !== 1'b1) frame_err++;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] xor_exp;
    int idle_bad;
    int busy0, done0, steps0;

    bank[0] = 16'h1234; bank[1] = 16'hABCD; bank[2] = 16'h0000; bank[3] = 16'hFFFF;
    bank[4] = 16'h00FF; bank[5] = 16'hFF00; bank[6] = 16'h8001; bank[7] = 16'h5A5A;
    exp_b = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h00, 8'hFF, 8'hFF,
              8'hFF, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h5A, 8'h5A};
    xor_exp = 8'h00;
    for (int i = 0; i < 2 * NREGS; i++) xor_exp ^= exp_b[i];

    // reset and idle
    reset = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sel", {29'd0, reg_sel}, 32'd0);
    reset = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || reg_sel !== 3'd0) idle_bad++;
    end
    chk("idle_50", idle_bad, 0);

    // basic dump, with start pulsed at r2 and r3 changed after its LOAD
    start = 1'b1;
    tick();
    start = 1'b0;
    busy0  = busy_cnt;
    done0  = done_cnt;
    steps0 = sel_steps;
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("load_tx", {31'd0, tx}, 32'd1);
    tick();
    chk("first_tx_low", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 2 * NREGS; i++) begin
      rx_byte("basic", b);
      chk($sformatf("basic_byte%0d", i), {24'd0, b}, {24'd0, exp_b[i]});
      if (i == 4) begin
        chk("r2_sel", {29'd0, reg_sel}, 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      if (i == 6) bank[3] = 16'h1111;
    end
`ifdef REG_DUMP_CHECKSUM_EN
    rx_byte("cks", b);
    chk("checksum_byte", {24'd0, b}, {24'd0, xor_exp});
`endif
    wait_done(4 * CPB);
    chk("done_busy_low", {31'd0, busy}, 32'd0);
    chk("done_sel_zero", {29'd0, reg_sel}, 32'd0);
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("basic_busy_len", busy_cnt - busy0, DUMP_LEN);
    chk("basic_done_cnt", done_cnt - done0, 1);
    chk("basic_sel_steps", sel_steps - steps0, NREGS - 1);
    chk("no_restart_idle", {31'd0, busy}, 32'd0);
    bank[3] = 16'hFFFF;

    // start held through done: back-to-back dumps
    start = 1'b1;
    tick();
    chk("held_accept", {31'd0, busy}, 32'd1);
    wait_done(DUMP_LEN + 8);
    chk("held_done_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("held_restart_busy", {31'd0, busy}, 32'd1);
    chk("held_restart_done", {31'd0, done}, 32'd0);
    chk("held_restart_load", {31'd0, tx}, 32'd1);
    tick();
    chk("held_restart_txlow", {31'd0, tx}, 32'd0);
    start = 1'b0;

    // reset during DATA bit 4 of r5 byte 1 (mid-bit is 1854 cycles after LOAD entry)
    repeat (1853) tick();
    chk("mid_sel", {29'd0, reg_sel}, 32'd5);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_tx", {31'd0, tx}, 32'd1);
    done0 = done_cnt;
    reset = 1'b0;
    tick();
    chk("mrst_tx", {31'd0, tx}, 32'd1);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_sel", {29'd0, reg_sel}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    repeat (20) tick();
    chk("mrst_no_done", done_cnt - done0, 0);
    chk("mrst_idle_tx", {31'd0, tx}, 32'd1);

    // full dump from r0 after the reset
    start = 1'b1;
    tick();
    start = 1'b0;
    busy0 = busy_cnt;
    rx_byte("again0", b);
    chk("again_byte0", {24'd0, b}, 32'h34);
    rx_byte("again1", b);
    chk("again_byte1", {24'd0, b}, 32'h12);
    wait_done(DUMP_LEN);
    chk("again_busy_len", busy_cnt - busy0, DUMP_LEN);
    chk("again_sel_zero", {29'd0, reg_sel}, 32'd0);

    chk("frame_errors", frame_err, 0);
    chk("sel_sequence", sel_bad, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
